// File: rtl/secret_mul_pkg.sv
// Shared types and constants for the secret-multiply engine command driver.
package secret_mul_pkg;

    localparam int TS_W_DEF = 64;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_IDLE_QUERY = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/secret_mul_driver_cmd_fifo.sv
// Small command FIFO (DEPTH x 2-bit) with occupancy count and synchronous clear.
module cmd_fifo
    import secret_mul_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic [1:0]              push_cmd,
    input  logic                    pop,
    output logic [1:0]              head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_cmd;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/secret_mul_driver.sv
// Issues buffered engine commands on a fixed schedule and captures query timestamps.
// Optional macro TIMING_LEAK_CHECK_EN builds a local cycle counter that flags delta mismatches.
module secret_mul_driver
    import secret_mul_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 2,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [1:0]      push_cmd,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [1:0]      eng_in,
    input  logic [TS_W-1:0] eng_out,
    output logic            rsp_valid,
    output logic [TS_W-1:0] rsp_ts,
    output logic [TS_W-1:0] rsp_delta,
    output logic            leak_flag
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP + 1);

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    cmd_t            eng_in_q, eng_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [TS_W-1:0] rsp_ts_q, rsp_ts_d;
    logic [TS_W-1:0] rsp_delta_q, rsp_delta_d;
    logic            ts_vld_q, ts_vld_d;
    logic            alive_q;

    logic            push_fire, run_start, step_end;
    logic            fifo_pop, fifo_clr;
    logic [1:0]      fifo_head;
    logic [CW-1:0]   fifo_count;
    logic [TS_W-1:0] ts_diff;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (fifo_clr),
        .push     (push_fire),
        .push_cmd (push_cmd),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    // alive_q keeps push_ready low while reset is held.
    assign push_ready = alive_q && (state_q == ST_IDLE) && (fifo_count < CW'(DEPTH));
    assign push_fire  = push_valid && push_ready;
    assign run_start  = (state_q == ST_IDLE) && start && (push_fire || (fifo_count != '0));
    assign ts_diff    = eng_out - rsp_ts_q;

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        eng_in_d    = CMD_IDLE_QUERY;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_ts_d    = rsp_ts_q;
        rsp_delta_d = rsp_delta_q;
        ts_vld_d    = ts_vld_q;
        fifo_pop    = 1'b0;
        fifo_clr    = 1'b0;
        step_end    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_start) begin
                    state_d  = ST_ISSUE;
                    busy_d   = 1'b1;
                    ts_vld_d = 1'b0;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                fifo_pop = 1'b1;
                eng_in_d = fifo_head;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (eng_in_q[0]) begin
                    state_d = ST_CAPT;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GW'(GAP);
                end
            end
            ST_CAPT: begin
                rsp_ts_d    = eng_out;
                rsp_delta_d = ts_vld_q ? ts_diff : '0;
                ts_vld_d    = 1'b1;
                rsp_valid_d = 1'b1;
                step_end    = 1'b1;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - GW'(1);
                step_end  = (gap_cnt_q == GW'(1));
            end
            default: state_d = ST_IDLE;
        endcase
        if (step_end) begin
            if (fifo_count != '0) begin
                state_d = ST_ISSUE;
            end else begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                fifo_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            eng_in_q    <= CMD_IDLE_QUERY;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ts_q    <= '0;
            rsp_delta_q <= '0;
            ts_vld_q    <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            eng_in_q    <= eng_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ts_q    <= rsp_ts_d;
            rsp_delta_q <= rsp_delta_d;
            ts_vld_q    <= ts_vld_d;
            alive_q     <= 1'b1;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign eng_in    = eng_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ts    = rsp_ts_q;
    assign rsp_delta = rsp_delta_q;

`ifdef TIMING_LEAK_CHECK_EN
    logic [TS_W-1:0] cyc_q, cyc_d;
    logic [TS_W-1:0] snap_q, snap_d;
    logic            leak_q, leak_d;

    // Local elapsed cycles between captures must equal the engine's reported delta.
    always_comb begin
        cyc_d  = cyc_q + TS_W'(1);
        snap_d = snap_q;
        leak_d = leak_q;
        if (run_start) leak_d = 1'b0;
        if (state_q == ST_CAPT) begin
            snap_d = cyc_q;
            if (ts_vld_q && ((cyc_q - snap_q) != ts_diff)) leak_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            snap_q <= '0;
            leak_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            snap_q <= snap_d;
            leak_q <= leak_d;
        end
    end

    assign leak_flag = leak_q;
`else
    assign leak_flag = 1'b0;
`endif

endmodule

// File: tb/tb_secret_mul_driver.sv
// Bench for secret_mul_driver: vector table, random programs, reset corner cases.
module tb_secret_mul_driver;
    import secret_mul_pkg::*;

    localparam int GAP    = 2;
    localparam int BUDGET = 120;

    logic        clk = 1'b0;
    logic        rst_n, push_valid, push_ready, start, busy, done, rsp_valid, leak_flag;
    logic [1:0]  push_cmd, eng_in;
    logic [63:0] eng_out, rsp_ts, rsp_delta;

    int total = 0;
    int bad   = 0;
    int run_cyc   = 0;
    int stall_cyc = -1;

    // Engine model: free-running wallclock starting near wrap, optionally stalled one cycle.
    logic [63:0] wc = 64'hFFFF_FFFF_FFFF_FFF0;
    assign eng_out = wc;
    always @(posedge clk) if (run_cyc != stall_cyc) wc <= wc + 64'd1;

    always #5 clk = ~clk;

    secret_mul_driver #(.DEPTH(8), .GAP(GAP), .TS_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready),
        .push_cmd(push_cmd), .start(start), .busy(busy), .done(done), .eng_in(eng_in),
        .eng_out(eng_out), .rsp_valid(rsp_valid), .rsp_ts(rsp_ts), .rsp_delta(rsp_delta),
        .leak_flag(leak_flag)
    );

    typedef struct {
        logic [15:0] cmds;
        int          n;
        bit          same;
        int          stall;
        int          exp_done;
        logic [63:0] exp_last_d;
        bit          has_q;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Push a program, start it, record the run, then rebuild the expected timeline from cmd bit0.
    task automatic do_run(input string tag, input logic [15:0] cmds, input int n, input bit same,
                          input int stall, input bit overflow, output int done_c,
                          output logic [63:0] last_d);
        logic [63:0] wc_obs  [0:BUDGET];
        logic [1:0]  eng_obs [0:BUDGET];
        logic [1:0]  exp_eng [0:BUDGET];
        logic        busy_obs[0:BUDGET];
        int          got_c[$];
        logic [63:0] got_ts[$];
        logic [63:0] got_d[$];
        int          t, nq, eng_bad, busy_bad, prev_capt;
        logic [63:0] prev_ts, ets, ed;
        bit          pv, exp_leak;
        logic [1:0]  ck;
        done_c = -1;
        last_d = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_push_ready%0d", tag, i), push_ready, 1);
            push_valid = 1'b1;
            push_cmd   = cmds[2*i +: 2];
            start      = same && (i == n - 1);
        end
        if (overflow) begin
            @(negedge clk);
            chk({tag, "_full_ready"}, push_ready, 0);
            push_valid = 1'b1;
            push_cmd   = 2'b10;
        end
        if (!same) begin
            @(negedge clk);
            push_valid = 1'b0;
            start      = 1'b1;
        end
        stall_cyc = stall;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            run_cyc = c;
            if (c == 1) begin
                start      = 1'b0;
                push_valid = 1'b0;
                chk({tag, "_leak_clr"}, leak_flag, 0);
            end
            wc_obs[c]   = eng_out;
            eng_obs[c]  = eng_in;
            busy_obs[c] = busy;
            if (rsp_valid) begin
                got_c.push_back(c);
                got_ts.push_back(rsp_ts);
                got_d.push_back(rsp_delta);
            end
            if (done) begin
                done_c = c;
                break;
            end
        end
        run_cyc   = 0;
        stall_cyc = -1;
        if (done_c < 0) begin
            chk({tag, "_done_timeout"}, 0, 1);
            return;
        end
        for (int c = 0; c <= BUDGET; c++) exp_eng[c] = CMD_IDLE_QUERY;
        t = 1; pv = 0; exp_leak = 0; nq = 0; prev_capt = 0; prev_ts = '0;
        for (int k = 0; k < n; k++) begin
            ck = cmds[2*k +: 2];
            exp_eng[t+1] = ck;
            if (ck[0]) begin
                ets = wc_obs[t+2];
                ed  = pv ? ets - prev_ts : 64'd0;
                if (pv && (64'(t + 2 - prev_capt) != ed)) exp_leak = 1;
                if (nq < got_c.size()) begin
                    chk($sformatf("%s_rsp%0d_cyc", tag, nq), got_c[nq], t + 3);
                    chk($sformatf("%s_rsp%0d_ts", tag, nq), got_ts[nq], ets);
                    chk($sformatf("%s_rsp%0d_delta", tag, nq), got_d[nq], ed);
                end
                nq++;
                prev_ts = ets; prev_capt = t + 2; pv = 1;
                t += 3;
            end else begin
                t += 2 + GAP;
            end
        end
        chk({tag, "_rsp_count"}, got_c.size(), nq);
        chk({tag, "_done_cycle"}, done_c, t);
        eng_bad = 0; busy_bad = 0;
        for (int c = 1; c <= done_c; c++) begin
            if (eng_obs[c] !== exp_eng[c]) eng_bad++;
            if (busy_obs[c] !== (c < done_c)) busy_bad++;
        end
        chk({tag, "_eng_in_sched"}, eng_bad, 0);
        chk({tag, "_busy_window"}, busy_bad, 0);
`ifdef TIMING_LEAK_CHECK_EN
        chk({tag, "_leak"}, leak_flag, exp_leak);
`else
        chk({tag, "_leak"}, leak_flag, 0);
`endif
        if (got_d.size() > 0) last_d = got_d[got_d.size()-1];
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int          dc, cnt_done, cnt_rsp, rn;
        logic [63:0] ld;
        logic [15:0] rc;
        rst_n = 1'b0; push_valid = 1'b0; push_cmd = 2'b00; start = 1'b0;

        vecs[0] = '{16'h0001, 1, 1'b1, -1,  4, 64'd0,  1'b1};
        vecs[1] = '{16'h0005, 2, 1'b1, -1,  7, 64'd3,  1'b1};
        vecs[2] = '{16'h0019, 3, 1'b0, -1, 11, 64'd7,  1'b1};
        vecs[3] = '{16'h0006, 2, 1'b0, -1,  8, 64'd0,  1'b1};
        vecs[4] = '{16'h0041, 4, 1'b0, -1, 15, 64'd11, 1'b1};
        vecs[5] = '{16'h0015, 3, 1'b0,  7, 10, 64'd2,  1'b1};

        #12;
        chk("rst_eng_in", eng_in, 2'b01);
        chk("rst_push_ready", push_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_ts", rsp_ts, 0);
        chk("rst_rsp_delta", rsp_delta, 0);
        chk("rst_leak", leak_flag, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_push_ready", push_ready, 1);

        foreach (vecs[i]) begin
            do_run($sformatf("vec%0d", i), vecs[i].cmds, vecs[i].n, vecs[i].same,
                   vecs[i].stall, 1'b0, dc, ld);
            chk($sformatf("vec%0d_tbl_done", i), dc, vecs[i].exp_done);
            if (vecs[i].has_q) chk($sformatf("vec%0d_tbl_delta", i), ld, vecs[i].exp_last_d);
        end

        do_run("full", 16'h5555, 8, 1'b0, -1, 1'b1, dc, ld);
        chk("full_tbl_done", dc, 25);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("empty_start_done", done, 1);
        chk("empty_start_busy", busy, 0);
        @(negedge clk);
        chk("empty_start_done_clr", done, 0);

        for (int r = 0; r < 8; r++) begin
            rn = $urandom_range(1, 8);
            rc = 16'($urandom);
            do_run($sformatf("rnd%0d", r), rc, rn, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4 * rn)) : -1,
                   1'b0, dc, ld);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); push_valid = 1'b1; push_cmd = 2'b01;
        end
        @(negedge clk); push_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_eng_in", eng_in, 2'b01);
        chk("midrst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        cnt_done = 0; cnt_rsp = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (rsp_valid) cnt_rsp++;
        end
        chk("midrst_no_done", cnt_done, 0);
        chk("midrst_no_rsp", cnt_rsp, 0);
        chk("midrst_push_ready", push_ready, 1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("midrst_fifo_empty_done", done, 1);
        chk("midrst_fifo_empty_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
